uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among up to NUM_REQ byte-stream requesters, such as the power-up banner sender, the capture-buffer dump and the command-response path. It grants the UART to one requester for a whole packet, so bytes from different requesters never interleave. It drives the UART's one-cycle start strobe and waits for its done pulse for each byte. It sits between the requester blocks and the UART TX core in the top level.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and defaults.
package uart_arb_pkg;

    localparam int DEFAULT_NUM_REQ          = 3;
    localparam int DEFAULT_LOCK_TIMEOUT_27M = 27000;   // 1 ms at 27 MHz

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        WAIT = ST_WAIT,
        HOLD = ST_HOLD
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin encoder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               hit,
    output logic [IW-1:0]      index
);

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int off);
        int s;
        s = (int'(p) + off) % NUM_REQ;
        return IW'(s);
    endfunction

    // Scan from the farthest candidate back to ptr so the nearest hit is written last.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap(ptr, i)]) begin
                hit   = 1'b1;
                index = wrap(ptr, i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the single UART transmitter to one requester for a whole packet,
// strobing the UART once per byte and waiting for its done pulse.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT_27M
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 uart_tx_data,
    output logic                       uart_tx_start,
    input  logic                       uart_tx_done,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       lock_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    // A timeout of 1 still needs a one-bit counter.
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

    arb_state_t    state, state_n;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] owner_inc;
    logic [IW-1:0] src;
    logic          pick_hit;
    logic          last_r;
    logic [CW-1:0] stall_cnt;
    logic          load;      // capture byte/last from src
    logic          grant;     // new owner taken from the round-robin pick
    logic          rr_adv;    // move rr_ptr past the current owner
    logic          cnt_clr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .hit   (pick_hit),
        .index (pick_idx)
    );

    assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    assign src       = grant ? pick_idx : owner;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state, per-cycle strobes and datapath enables.
    always_comb begin
        state_n       = state;
        load          = 1'b0;
        grant         = 1'b0;
        rr_adv        = 1'b0;
        cnt_clr       = 1'b0;
        uart_tx_start = 1'b0;
        req_ready     = '0;
        lock_timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    grant   = 1'b1;
                    load    = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                uart_tx_start    = 1'b1;
                req_ready[owner] = 1'b1;
                state_n          = WAIT;
            end
            WAIT: begin
                if (uart_tx_done) begin
                    if (last_r) begin
                        rr_adv  = 1'b1;
                        state_n = IDLE;
                    end else if (req_valid[owner]) begin
                        load    = 1'b1;
                        state_n = SEND;
                    end else begin
                        cnt_clr = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                // The lock is kept: nobody else is considered until the owner
                // resumes or its stall runs out.
                if (req_valid[owner]) begin
                    load    = 1'b1;
                    state_n = SEND;
                end else if (stall_cnt == CNT_LAST) begin
                    lock_timeout = 1'b1;
                    rr_adv       = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Owner, byte register, round-robin pointer and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner        <= '0;
            uart_tx_data <= 8'h00;
            last_r       <= 1'b0;
            rr_ptr       <= '0;
            stall_cnt    <= '0;
        end else begin
            if (grant) owner <= pick_idx;
            if (load) begin
                uart_tx_data <= req_data[8*src +: 8];
                last_r       <= req_last[src];
            end
            if (rr_adv) rr_ptr <= owner_inc;
            if (cnt_clr)
                stall_cnt <= '0;
            else if (state == HOLD && stall_cnt != '1)
                stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, UART model, and
// expected {owner, byte} entries checked at each start strobe.
module tb_uart_tx_arbiter;

    localparam int NR       = 3;
    localparam int LT       = 120;   // long enough that a 100-cycle stall survives
    localparam int UART_LAT = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_last, req_ready;
    logic [8*NR-1:0] req_data;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_start, uart_tx_done, busy, lock_timeout;
    logic [1:0]      owner;

    uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_done  (uart_tx_done),
        .owner         (owner),
        .busy          (busy),
        .lock_timeout  (lock_timeout)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    logic [8:0] feed [NR][$];     // {last, byte} per requester
    logic [9:0] exp_q [$];        // {owner, byte}
    logic [NR-1:0] stall;
    int         ready_cnt [NR];
    int         cyc = 0, lt_cnt = 0, t_done = 0, t_lt = 0, t_lt_done = 0, t_start = 0, ucnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int r, input logic [7:0] b, input logic l);
        feed[r].push_back({l, b});
    endtask

    task automatic expb(input int r, input logic [7:0] b);
        exp_q.push_back({r[1:0], b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_q", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic wait_ready(input int r, input int target, input int budget);
        int n = 0;
        while (ready_cnt[r] < target && n < budget) begin
            step();
            n++;
        end
        chk("wait_ready", ready_cnt[r] >= target, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester and UART models plus output monitor, all on the falling edge.
    initial begin
        logic [9:0] e;
        uart_tx_done = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        stall     = '0;
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ucnt = 0;
                uart_tx_done = 1'b0;
            end else begin
                uart_tx_done = 1'b0;
                if (uart_tx_start) begin
                    t_start = cyc;
                    if (exp_q.size() == 0) begin
                        chk("extra_start", {22'd0, owner, uart_tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", uart_tx_data, e[7:0]);
                        chk("tx_owner", owner, e[9:8]);
                        chk("ready_onehot", req_ready, 32'd1 << e[9:8]);
                    end
                    ucnt = UART_LAT;
                end else if (ucnt > 0) begin
                    ucnt--;
                    if (ucnt == 0) begin
                        uart_tx_done = 1'b1;
                        t_done = cyc;
                    end
                end
                if (lock_timeout) begin
                    lt_cnt++;
                    t_lt = cyc;
                    t_lt_done = t_done;
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) begin
                        ready_cnt[i]++;
                        if (feed[i].size() > 0) feed[i].delete(0);
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = (feed[i].size() > 0) && !stall[i];
                if (feed[i].size() > 0) begin
                    req_data[8*i +: 8] = feed[i][0][7:0];
                    req_last[i]        = feed[i][0][8];
                end else begin
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] str [5];
        int base, b1, lt0;
        str = '{8'h73, 8'h74, 8'h61, 8'h72, 8'h74};

        reset = 1'b1;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_start", uart_tx_start, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", uart_tx_data, 8'h00);
        chk("rst_owner", owner, 0);
        chk("rst_lt", lock_timeout, 0);
        reset = 1'b0;
        step();

        // Simultaneous req 0 and req 2 from rr_ptr 0: whole packets, no interleave.
        for (int i = 0; i < 3; i++) begin
            put(0, 8'h11 + 8'(i), i == 2);
            put(2, 8'h21 + 8'(i), i == 2);
        end
        for (int i = 0; i < 3; i++) expb(0, 8'h11 + 8'(i));
        for (int i = 0; i < 3; i++) expb(2, 8'h21 + 8'(i));
        drain(2000);
        chk("sim_owner_last", owner, 2);

        // Fairness: everybody offers two 1-byte packets, rr_ptr back at 0.
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NR; r++) begin
                put(r, 8'h40 + 8'(16*k + r), 1'b1);
                expb(r, 8'h40 + 8'(16*k + r));
            end
        drain(2000);

        // Single packet "start" from req 0.
        base = ready_cnt[0];
        for (int i = 0; i < 5; i++) begin
            put(0, str[i], i == 4);
            expb(0, str[i]);
        end
        drain(2000);
        chk("start_ready0", ready_cnt[0] - base, 5);

        // rr_ptr is now 1: req 1 beats req 0.
        put(0, 8'hA0, 1'b1);
        put(1, 8'hB0, 1'b1);
        expb(1, 8'hB0);
        expb(0, 8'hA0);
        drain(1000);

        // Owner stall: req 0 pauses 100 cycles after byte 2 while req 1 waits.
        base = ready_cnt[0];
        for (int i = 0; i < 4; i++) begin
            put(0, 8'h50 + 8'(i), i == 3);
            expb(0, 8'h50 + 8'(i));
        end
        wait_ready(0, base + 1, 200);
        put(1, 8'h60, 1'b1);
        expb(1, 8'h60);
        wait_ready(0, base + 2, 200);
        stall[0] = 1'b1;
        b1 = ready_cnt[1];
        repeat (100) step();
        chk("hold_busy", busy, 1);
        chk("hold_no_ready1", ready_cnt[1] - b1, 0);
        chk("hold_owner", owner, 0);
        chk("hold_pending", exp_q.size(), 3);
        stall[0] = 1'b0;
        drain(2000);

        // Lock revoke: req 0 stalls forever after its first byte.
        lt0  = lt_cnt;
        base = ready_cnt[0];
        put(0, 8'h70, 1'b0);
        put(0, 8'h71, 1'b1);
        expb(0, 8'h70);
        wait_ready(0, base + 1, 200);
        stall[0] = 1'b1;
        put(1, 8'h80, 1'b1);
        expb(1, 8'h80);
        drain(LT + 500);
        chk("lt_pulse", lt_cnt - lt0, 1);
        chk("lt_latency", t_lt - t_lt_done, LT);
        chk("grant_after_lt", t_start - t_lt, 2);
        feed[0].delete();
        stall[0] = 1'b0;

        // Reset mid-WAIT on byte 2 of a req 1 packet (rr_ptr is 2 beforehand).
        base = ready_cnt[1];
        put(1, 8'h90, 1'b0);
        put(1, 8'h91, 1'b0);
        put(1, 8'h92, 1'b1);
        expb(1, 8'h90);
        expb(1, 8'h91);
        wait_ready(1, base + 2, 200);
        repeat (3) step();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) feed[i].delete();
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_data", uart_tx_data, 8'h00);
        chk("rstw_start", uart_tx_start, 0);
        chk("rstw_owner", owner, 0);
        chk("rstw_q", exp_q.size(), 0);
        step();
        reset = 1'b0;
        put(1, 8'hC1, 1'b1);
        put(2, 8'hC2, 1'b1);
        expb(1, 8'hC1);
        expb(2, 8'hC2);
        drain(1000);

        chk("lt_total", lt_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
